sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch requester and the data (load/store) requester.
- Sits between the fetch/memory pipeline stages and the single external sram-like bus.
- Serialises accesses with at most one outstanding transaction.
- Routes address and data handshakes back to the requester that owns the current transaction.

Parameters:
ADDR_W, 32, address width of all three ports
DATA_W, 32, data width of all three ports

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
inst_req  in  1  fetch request; held high until inst_addr_ok
inst_addr  in  ADDR_W  fetch address
inst_addr_ok  out  1  one-cycle pulse: fetch address accepted by memory
inst_data_ok  out  1  one-cycle pulse: inst_rdata valid
inst_rdata  out  DATA_W  fetch read data
data_req  in  1  data request; held high until data_addr_ok
data_wr  in  1  1 = store, 0 = load
data_size  in  2  0 = byte, 1 = half, 2 = word
data_addr  in  ADDR_W  data address
data_wdata  in  DATA_W  store data
data_addr_ok  out  1  one-cycle pulse: data address accepted
data_data_ok  out  1  one-cycle pulse: load data valid / store done
data_rdata  out  DATA_W  load data
mem_req  out  1  memory request
mem_wr  out  1  memory write
mem_size  out  2  memory access size
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_addr_ok  in  1  memory accepted address
mem_data_ok  in  1  memory data phase complete
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (asynchronous, resetn low):
  - state = IDLE; owner = INST; last_grant = INST.
  - Holding registers (wr, size, addr, wdata) = 0.
  - mem_req = 0; all *_addr_ok and *_data_ok = 0.
  - Reset mid-transaction abandons it; no data_ok is ever issued for it.
- Three-state FSM: IDLE, ADDR, DATA.
- IDLE:
  - Arbitrate among requesters with req high. Default policy: data_req has priority over inst_req.
  - On grant: latch owner and request fields into holding registers; next state = ADDR.
  - Instruction grants latch wr = 0, size = 2'b10.
  - No request: stay in IDLE.
- ADDR:
  - mem_req = 1; mem_wr/mem_size/mem_addr/mem_wdata driven from holding registers only, so they are stable while mem_req is high.
  - On mem_addr_ok: pulse the owner's addr_ok in the same cycle (combinational: mem_addr_ok & state==ADDR & owner); next state = DATA.
  - The non-owner's req is ignored.
- DATA:
  - mem_req = 0.
  - On mem_data_ok: pulse the owner's data_ok in the same cycle.
  - On the same edge: if any req is pending, arbitrate and go directly to ADDR (back-to-back, no IDLE bubble); else go to IDLE.
- Latency: request seen in IDLE -> mem_req asserted next cycle. Minimum 3 cycles from grant to data_ok for a 1-cycle memory.
- inst_rdata and data_rdata both equal mem_rdata combinationally; valid only when the corresponding data_ok is high.
- Bus rules:
  - mem_addr_ok is ignored outside ADDR.
  - mem_data_ok is ignored outside DATA; it may not be honoured in the same cycle as mem_addr_ok.
  - inst_data_ok and data_data_ok are never high together; inst_addr_ok and data_addr_ok are never high together.
- A requester dropping req before its addr_ok does not cancel an already-latched grant; the transaction completes.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: when inst_req and data_req are both high at arbitration, grant the requester opposite to last_grant. last_grant updates on every grant.
- Undefined: fixed priority, data first; last_grant logic is absent.

Test Plan:
- Single fetch: inst_req=1, inst_addr=0xbfc00000, memory gives addr_ok 1 cycle later and data_ok next cycle with 0x3c1d0001 -> mem_addr=0xbfc00000, mem_wr=0, mem_size=2; one inst_addr_ok pulse; inst_data_ok pulse with inst_rdata=0x3c1d0001; data_* outputs stay 0.
- Simultaneous requests: inst_req and data_req high together, data store addr 0x80000010, wdata 0x12345678, size 2 -> store issued first (mem_wr=1); fetch follows back-to-back, with mem_req rising in the cycle after the store's data_ok. Under ARB_ROUND_ROBIN_EN with last_grant=DATA, the fetch is issued first.
- Memory stall: mem_addr_ok held low 5 cycles -> mem_req and mem_addr stable all 5 cycles; no addr_ok pulses.
- Sub-word load: data_size=0, addr 0x80000003 -> mem_size=0, mem_addr=0x80000003; data_data_ok carries mem_rdata unchanged.
- Reset in DATA: resetn low while waiting for data_ok, then mem_data_ok=1 after reset release -> no data_ok pulse; FSM in IDLE; mem_req=0.
- Spurious handshakes: mem_data_ok=1 in IDLE, mem_addr_ok=1 in DATA -> no *_ok outputs; state unchanged.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like bus between the fetch and load/store requesters, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN to alternate grants on contention; default is fixed data-first priority.
module sram_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,

  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,

  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                wr_q, wr_d;
  logic [1:0]          size_q, size_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                grantData;
  logic                arbitrate;

`ifdef ARB_ROUND_ROBIN_EN
  logic                lastGrant_q, lastGrant_d;

  // On contention the requester that did not win last time goes first.
  assign grantData = data_req & (~inst_req | (lastGrant_q == OWN_INST));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lastGrant_q <= OWN_INST;
    else         lastGrant_q <= lastGrant_d;
  end

  always_comb begin
    lastGrant_d = lastGrant_q;
    if (arbitrate) lastGrant_d = grantData;
  end
`else
  assign grantData = data_req;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      owner_q <= OWN_INST;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Arbitration happens in IDLE and again on data completion so back-to-back grants skip IDLE.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    wr_d      = wr_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    arbitrate = 1'b0;

    case (state_q)
      IDLE: begin
        arbitrate = inst_req | data_req;
      end
      ADDR: begin
        if (mem_addr_ok) state_d = DATA;
      end
      DATA: begin
        if (mem_data_ok) begin
          if (inst_req | data_req) arbitrate = 1'b1;
          else                     state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (arbitrate) begin
      state_d = ADDR;
      if (grantData) begin
        owner_d = OWN_DATA;
        wr_d    = data_wr;
        size_d  = data_size;
        addr_d  = data_addr;
        wdata_d = data_wdata;
      end else begin
        owner_d = OWN_INST;
        wr_d    = 1'b0;
        size_d  = 2'b10;
        addr_d  = inst_addr;
        wdata_d = '0;
      end
    end
  end

  // Bus fields come only from holding registers so they stay stable through address stalls.
  always_comb begin
    mem_req      = (state_q == ADDR);
    mem_wr       = wr_q;
    mem_size     = size_q;
    mem_addr     = addr_q;
    mem_wdata    = wdata_q;
    inst_addr_ok = mem_addr_ok & (state_q == ADDR) & (owner_q == OWN_INST);
    data_addr_ok = mem_addr_ok & (state_q == ADDR) & (owner_q == OWN_DATA);
    inst_data_ok = mem_data_ok & (state_q == DATA) & (owner_q == OWN_INST);
    data_data_ok = mem_data_ok & (state_q == DATA) & (owner_q == OWN_DATA);
    inst_rdata   = mem_rdata;
    data_rdata   = mem_rdata;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: a small memory model pops expected transactions
// when the DUT issues them and checks handshake pulses and read data every cycle.
module tb_sram_port_arbiter;

  typedef struct {
    logic        isData;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  logic        clk;
  logic        resetn;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int   errors = 0;
  int   checks = 0;
  int   cycle = 0;
  int   doneCnt = 0;
  int   lastDataOkCycle = 0;
  int   addrStall = 0;
  int   mPhase = 0;
  int   stallCnt = 0;
  int   b2bArmDone = 0;
  bit   memAuto = 0;
  bit   chkB2B = 0;
  logic [3:0] expOk;
  txn_t cur;
  txn_t sbQ[$];

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cycle);
    end
  endtask

  task automatic applyStimulus(input logic isData, input logic wr, input logic [1:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata);
    txn_t t;
    t.isData = isData; t.wr = isData ? wr : 1'b0; t.size = isData ? size : 2'b10;
    t.addr = addr; t.wdata = wdata; t.rdata = rdata;
    sbQ.push_back(t);
    if (isData) begin
      data_wr = wr; data_size = size; data_addr = addr; data_wdata = wdata; data_req = 1'b1;
    end else begin
      inst_addr = addr; inst_req = 1'b1;
    end
  endtask

  task automatic waitDone(input int target);
    for (int i = 0; i < 80 && doneCnt < target; i++) begin
      @(negedge clk); #2;
    end
    checkOutput("doneCount", doneCnt, target);
    @(negedge clk); #2;
  endtask

  task automatic nextCycle();
    @(negedge clk); #2;
  endtask

  // Memory model plus per-cycle handshake monitor; active only while memAuto is set.
  always @(negedge clk) begin
    if (memAuto) begin
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      mem_rdata   = 32'hdeadbeef;
      expOk       = 4'b0000;
      if (mPhase == 0 && mem_req) begin
        checkOutput("sbPending", sbQ.size() != 0, 1);
        if (sbQ.size() != 0) begin
          cur = sbQ.pop_front();
          checkOutput("memWr", mem_wr, cur.wr);
          checkOutput("memSize", mem_size, cur.size);
          checkOutput("memAddr", mem_addr, cur.addr);
          if (cur.isData) checkOutput("memWdata", mem_wdata, cur.wdata);
          if (chkB2B && doneCnt != b2bArmDone) begin
            checkOutput("b2bGap", cycle - lastDataOkCycle, 1);
            chkB2B = 0;
          end
          mPhase = 1;
          stallCnt = 0;
        end
      end
      if (mPhase == 1) begin
        checkOutput("addrPhaseReq", mem_req, 1);
        checkOutput("addrStable", mem_addr, cur.addr);
        if (stallCnt >= addrStall) begin
          mem_addr_ok = 1'b1;
          expOk = cur.isData ? 4'b0100 : 4'b1000;
          mPhase = 2;
        end else begin
          stallCnt++;
        end
      end else if (mPhase == 2) begin
        checkOutput("dataPhaseReq", mem_req, 0);
        mem_data_ok = 1'b1;
        mem_rdata = cur.rdata;
        expOk = cur.isData ? 4'b0001 : 4'b0010;
        mPhase = 0;
        doneCnt++;
        lastDataOkCycle = cycle;
      end
      #1;
      checkOutput("okPulses", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, expOk);
      if (expOk[0]) checkOutput("dataRdata", data_rdata, cur.rdata);
      if (expOk[1]) checkOutput("instRdata", inst_rdata, cur.rdata);
      if (inst_addr_ok) inst_req = 1'b0;
      if (data_addr_ok) data_req = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetn = 1'b0;
    inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0; data_size = 0;
    data_addr = 0; data_wdata = 0; mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    #3;
    checkOutput("rstMemReq", mem_req, 0);
    checkOutput("rstMemAddr", mem_addr, 0);
    checkOutput("rstMemWr", mem_wr, 0);
    checkOutput("rstMemSize", mem_size, 0);
    checkOutput("rstOks", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 4'b0000);
    resetn = 1'b1;
    nextCycle();
    mPhase = 0;
    memAuto = 1;

    // Single fetch with address accepted one cycle late.
    addrStall = 1;
    applyStimulus(1'b0, 1'b0, 2'b10, 32'hbfc00000, 32'h0, 32'h3c1d0001);
    waitDone(1);
    addrStall = 0;

    // Simultaneous store and fetch: store first, fetch back-to-back.
    b2bArmDone = doneCnt;
    chkB2B = 1;
    applyStimulus(1'b1, 1'b1, 2'b10, 32'h80000010, 32'h12345678, 32'h0);
    applyStimulus(1'b0, 1'b0, 2'b10, 32'hbfc00004, 32'h0, 32'h8fbf0010);
    waitDone(3);

    // Address stall of five cycles.
    addrStall = 5;
    applyStimulus(1'b1, 1'b0, 2'b10, 32'h80000020, 32'h0, 32'hcafef00d);
    waitDone(4);
    addrStall = 0;

    // Byte load at an unaligned address.
    applyStimulus(1'b1, 1'b0, 2'b00, 32'h80000003, 32'h0, 32'ha5a5a5a5);
    waitDone(5);

    // Contention right after a data grant exposes the arbitration policy.
    b2bArmDone = doneCnt;
    chkB2B = 1;
`ifdef ARB_ROUND_ROBIN_EN
    applyStimulus(1'b0, 1'b0, 2'b10, 32'hbfc00008, 32'h0, 32'h24020001);
    applyStimulus(1'b1, 1'b1, 2'b01, 32'h80000040, 32'h0000beef, 32'h0);
`else
    applyStimulus(1'b1, 1'b1, 2'b01, 32'h80000040, 32'h0000beef, 32'h0);
    applyStimulus(1'b0, 1'b0, 2'b10, 32'hbfc00008, 32'h0, 32'h24020001);
`endif
    waitDone(7);

    // Manual bus driving: spurious handshakes.
    memAuto = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'h0;
    nextCycle();
    mem_data_ok = 1'b1;
    #1;
    checkOutput("spurDataIdleOks", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 4'b0000);
    checkOutput("spurDataIdleReq", mem_req, 0);
    nextCycle();
    mem_data_ok = 1'b0;
    inst_addr = 32'hbfc00100; inst_req = 1'b1;
    nextCycle();
    checkOutput("manAddrReq", mem_req, 1);
    checkOutput("manAddr", mem_addr, 32'hbfc00100);
    mem_addr_ok = 1'b1;
    #1;
    checkOutput("manAddrOk", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 4'b1000);
    inst_req = 1'b0;
    nextCycle();
    #1;
    checkOutput("spurAddrDataOks", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 4'b0000);
    checkOutput("spurAddrDataReq", mem_req, 0);
    nextCycle();
    mem_addr_ok = 1'b0;
    checkOutput("stillDataReq", mem_req, 0);
    mem_data_ok = 1'b1; mem_rdata = 32'h11223344;
    #1;
    checkOutput("manDataOk", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 4'b0010);
    checkOutput("manInstRdata", inst_rdata, 32'h11223344);
    nextCycle();
    mem_data_ok = 1'b0;
    checkOutput("manIdleReq", mem_req, 0);

    // Reset while waiting for read data.
    inst_addr = 32'hbfc00200; inst_req = 1'b1;
    nextCycle();
    checkOutput("rstTxnReq", mem_req, 1);
    mem_addr_ok = 1'b1;
    inst_req = 1'b0;
    nextCycle();
    mem_addr_ok = 1'b0;
    resetn = 1'b0;
    #1;
    checkOutput("rstMidReq", mem_req, 0);
    checkOutput("rstMidAddr", mem_addr, 0);
    nextCycle();
    resetn = 1'b1;
    nextCycle();
    mem_data_ok = 1'b1; mem_rdata = 32'h55aa55aa;
    #1;
    checkOutput("rstNoDataOk", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 4'b0000);
    checkOutput("rstIdleReq", mem_req, 0);
    nextCycle();
    mem_data_ok = 1'b0;
    checkOutput("rstStillIdle", mem_req, 0);

    // Normal traffic resumes after reset.
    mPhase = 0;
    memAuto = 1;
    applyStimulus(1'b0, 1'b0, 2'b10, 32'hbfc00010, 32'h0, 32'h24080001);
    waitDone(8);
    applyStimulus(1'b1, 1'b1, 2'b00, 32'h80000051, 32'h000000ab, 32'h0);
    waitDone(9);

    checkOutput("sbEmpty", sbQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
